// File: rtl/byte_sum_transmitter_if.sv
// byte_sum_transmitter_if: valid/ready byte bus; master drives tx_data/tx_valid/tx_last, slave drives tx_ready
interface byte_sum_transmitter_if #(
  parameter int DATAW = 8
);
  logic [DATAW-1:0] tx_data;
  logic tx_valid, tx_ready, tx_last;
  modport master(output tx_data, tx_valid, tx_last, input tx_ready);
  modport slave(input tx_data, tx_valid, tx_last, output tx_ready);
endinterface

// File: rtl/byte_sum_transmitter.sv
// byte_sum_transmitter: streams NBYTES loaded bytes on a valid/ready bus, then strobes their running sum
// Ports: clk, rst_n (async active-low); load_i/data_i frame load (sampled in IDLE only); busy_o high in SEND/DONE;
//        tx (master): tx_data/tx_valid/tx_last out, tx_ready in; sum_o/sum_vld_o final sum with one-cycle strobe.
// Option: define BYTE_SKIP_MASK_EN to add skip_i, a per-byte mask of bytes neither sent nor summed.
module byte_sum_transmitter #(
  parameter int DATAW = 8,
  parameter int NBYTES = 16,
  parameter int SUMW = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic [NBYTES*DATAW-1:0] data_i,
`ifdef BYTE_SKIP_MASK_EN
  input  logic [NBYTES-1:0] skip_i,
`endif
  output logic busy_o,
  byte_sum_transmitter_if.master tx,
  output logic [SUMW-1:0] sum_o,
  output logic sum_vld_o
);
  localparam int IW = $clog2(NBYTES);
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [NBYTES*DATAW-1:0] frame_q, frame_d;
  logic [IW-1:0] idx_q, idx_d, first_idx, nxt_idx;
  logic [SUMW-1:0] sum_q, sum_d;
  logic [DATAW-1:0] cur;
  logic has_first, has_nxt, fire;
`ifdef BYTE_SKIP_MASK_EN
  logic [NBYTES-1:0] skip_q;
  // Downward scans leave the lowest qualifying index: first unskipped byte of the new mask, next unskipped byte after idx_q.
  always_comb begin
    has_first = 1'b0;
    first_idx = '0;
    has_nxt = 1'b0;
    nxt_idx = '0;
    for (int k = NBYTES - 1; k >= 0; k--) begin
      if (!skip_i[k]) begin
        has_first = 1'b1;
        first_idx = IW'(k);
      end
      if (k > int'(idx_q) && !skip_q[k]) begin
        has_nxt = 1'b1;
        nxt_idx = IW'(k);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) skip_q <= '0;
    else if (state_q == IDLE && load_i) skip_q <= skip_i;
`else
  assign has_first = 1'b1;
  assign first_idx = '0;
  assign has_nxt = idx_q != IW'(NBYTES - 1);
  assign nxt_idx = idx_q + 1'b1;
`endif
  assign cur = frame_q[idx_q*DATAW +: DATAW];
  assign tx.tx_valid = state_q == SEND;
  assign tx.tx_data = tx.tx_valid ? cur : '0;
  assign tx.tx_last = tx.tx_valid & ~has_nxt;
  assign fire = tx.tx_valid & tx.tx_ready;
  assign busy_o = state_q != IDLE;
  assign sum_vld_o = state_q == DONE;
  assign sum_o = sum_q;
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d = idx_q;
    sum_d = sum_q;
    if (state_q == IDLE && load_i) begin
      frame_d = data_i;
      idx_d = first_idx;
      sum_d = '0;
      state_d = has_first ? SEND : DONE;
    end else if (fire) begin
      sum_d = sum_q + SUMW'(cur);
      idx_d = has_nxt ? nxt_idx : idx_q;
      state_d = has_nxt ? SEND : DONE;
    end else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      idx_q <= '0;
      sum_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q <= idx_d;
      sum_q <= sum_d;
    end
endmodule

// File: tb/tb_byte_sum_transmitter.sv
// tb_byte_sum_transmitter: directed frames with hand-computed sums against byte_sum_transmitter
module tb_byte_sum_transmitter;
  localparam int NB = 16;
  logic clk = 0, rst_n = 0, load_i = 0;
  logic [NB*8-1:0] data_i = '0;
`ifdef BYTE_SKIP_MASK_EN
  logic [NB-1:0] skip = '0;
`endif
  logic busy_o, sum_vld_o;
  logic [31:0] sum_o;
  int checks = 0, errors = 0;
  byte_sum_transmitter_if #(.DATAW(8)) bus();
  byte_sum_transmitter #(.DATAW(8), .NBYTES(NB), .SUMW(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_i(load_i),
    .data_i(data_i),
`ifdef BYTE_SKIP_MASK_EN
    .skip_i(skip),
`endif
    .busy_o(busy_o),
    .tx(bus),
    .sum_o(sum_o),
    .sum_vld_o(sum_vld_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [NB*8-1:0] d, input logic [NB-1:0] sk, input bit tog, input bit mid,
                     input logic [31:0] exp_sum, input string tag);
    logic [7:0] q[$];
    int n = 0, cyc = 1;
    bit done = 0;
    for (int k = 0; k < NB; k++) if (!sk[k]) q.push_back(d[k*8 +: 8]);
`ifdef BYTE_SKIP_MASK_EN
    skip = sk;
`endif
    data_i = d;
    load_i = 1;
    @(posedge clk); #1;
    load_i = 0;
    data_i = ~d;
    while (!done && cyc < 200) begin
      if (mid && cyc == 3) begin
        load_i = 1;
        data_i = {NB{8'hAA}};
      end else load_i = 0;
      bus.tx_ready = tog ? cyc[0] : 1'b1;
      chk({tag, " busy"}, busy_o, 1);
      if (bus.tx_valid) begin
        if (n < q.size()) begin
          chk({tag, " data"}, bus.tx_data, q[n]);
          chk({tag, " last"}, bus.tx_last, n == q.size() - 1);
        end else chk({tag, " extra byte"}, 1, 0);
      end
      if (sum_vld_o) begin
        chk({tag, " sum"}, sum_o, exp_sum);
        chk({tag, " count"}, n, q.size());
        if (!tog) chk({tag, " cycles"}, cyc, q.size() + 1);
        done = 1;
      end
      if (bus.tx_valid && bus.tx_ready) n++;
      @(posedge clk); #1;
      cyc++;
    end
    load_i = 0;
    if (!done) chk({tag, " timeout"}, 0, 1);
    chk({tag, " idle busy"}, busy_o, 0);
    chk({tag, " idle vld"}, sum_vld_o, 0);
    chk({tag, " idle valid"}, bus.tx_valid, 0);
    chk({tag, " sum hold"}, sum_o, exp_sum);
  endtask
  logic [NB*8-1:0] d1, d3;
  initial begin
    bus.tx_ready = 1;
    for (int k = 0; k < NB; k++) begin
      d1[k*8 +: 8] = 8'(k + 1);
      d3[k*8 +: 8] = 8'(2 * k + 1);
    end
    #1;
    chk("reset valid", bus.tx_valid, 0);
    chk("reset busy", busy_o, 0);
    chk("reset vld", sum_vld_o, 0);
    chk("reset sum", sum_o, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    run(d1, '0, 0, 0, 32'd136, "seq");
    run({NB{8'hFF}}, '0, 1, 0, 32'd4080, "ff toggle");
    run(d3, '0, 0, 1, 32'd256, "mid load");
    data_i = d1;
    load_i = 1;
    bus.tx_ready = 1;
    @(posedge clk); #1;
    load_i = 0;
    repeat (5) begin @(posedge clk); #1; end
    chk("rst pre byte", bus.tx_data, 6);
    rst_n = 0;
    #1;
    chk("rst valid", bus.tx_valid, 0);
    chk("rst data", bus.tx_data, 0);
    chk("rst last", bus.tx_last, 0);
    chk("rst busy", busy_o, 0);
    chk("rst sum", sum_o, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst no vld", sum_vld_o, 0);
    end
    rst_n = 1;
    @(posedge clk); #1;
    run(d1, '0, 0, 0, 32'd136, "post rst");
`ifdef BYTE_SKIP_MASK_EN
    run(d1, 16'h0400, 0, 0, 32'd125, "skip one");
    run(d1, 16'hFFFF, 0, 0, 32'd0, "skip all");
    run(d1, 16'h8001, 1, 0, 32'd119, "skip ends");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
